// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: round-robin two-master Wishbone arbiter in front of a single-port RAM,
// with a forced idle gap between transfers and a timeout that answers with a bus error.
module wb_ram_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req0, req1, busy, g_cyc, tmo, ack, err;
  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign busy  = state_q == BUSY;
  assign g_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;
  assign tmo   = cnt_q == CW'(TIMEOUT - 1);
  assign ack   = busy & s_ack_i;
  // abort outranks timeout, so an error needs the granted cycle still open
  assign err   = busy & ~s_ack_i & g_cyc & tmo;
  assign s_cyc_o  = busy & g_cyc;
  assign s_stb_o  = busy & (gnt_q ? m1_stb_i : m0_stb_i);
  assign s_we_o   = busy & (gnt_q ? m1_we_i : m0_we_i);
  assign s_sel_o  = busy ? (gnt_q ? m1_sel_i : m0_sel_i) : '0;
  assign s_adr_o  = busy ? (gnt_q ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o  = busy ? (gnt_q ? m1_dat_i : m0_dat_i) : '0;
  assign m0_ack_o = ack & ~gnt_q;
  assign m1_ack_o = ack & gnt_q;
  assign m0_err_o = err & ~gnt_q;
  assign m1_err_o = err & gnt_q;
  assign m0_dat_o = rst_n_i ? s_dat_i : '0;
  assign m1_dat_o = rst_n_i ? s_dat_i : '0;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (req0 | req1) begin
        state_d = BUSY;
        gnt_d   = (req0 & req1) ? ~last_q : req1;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = tmo ? cnt_q : cnt_q + 1'b1;
      if (s_ack_i | ~g_cyc | tmo) begin
        state_d = IDLE;
        last_d  = gnt_q;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
